// File: rtl/fifo_param_pkg.sv
// Shared definitions for the parametrised FIFO: FSM state encodings and the
// next-state decision made from the request pair and the current fill level.
package fifo_param_pkg;

  typedef enum logic [2:0] {
    INIT     = 3'd0,
    WRITE    = 3'd1,
    READ     = 3'd2,
    WR_ERROR = 3'd3,
    RD_ERROR = 3'd4,
    NO_OP    = 3'd5,
    RDWR     = 3'd6
  } state_t;

  // Decide which transaction the coming edge performs. A read on an empty
  // FIFO paired with a write still lets the write through; the rejected read
  // is flagged separately by the caller.
  function automatic state_t fifo_next_state(input logic wr,
                                             input logic rd,
                                             input logic is_full,
                                             input logic is_empty);
    state_t nxt;
    case ({wr, rd})
      2'b00:   nxt = NO_OP;
      2'b10:   nxt = is_full  ? WR_ERROR : WRITE;
      2'b01:   nxt = is_empty ? RD_ERROR : READ;
      2'b11:   nxt = is_empty ? WRITE    : RDWR;
      default: nxt = state_t'('x);
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/fifo_param_cal.sv
// Next-pointer / next-count calculator: turns the transaction chosen for the
// coming edge into memory enables and the updated head, tail and count.
module fifo_param_cal
  import fifo_param_pkg::*;
#(
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH)
) (
  input  state_t      state_nxt,
  input  logic [AW-1:0] head,
  input  logic [AW-1:0] tail,
  input  logic [AW:0]   count,
  output logic [AW-1:0] head_nxt,
  output logic [AW-1:0] tail_nxt,
  output logic [AW:0]   count_nxt,
  output logic          we,
  output logic          re
);

  // Per-transaction pointer and count update; pointers wrap by AW-bit overflow.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latch).
    head_nxt  = head;
    tail_nxt  = tail;
    count_nxt = count;
    we        = 1'b0;
    re        = 1'b0;
    case (state_nxt)
      WRITE: begin
        we        = 1'b1;
        tail_nxt  = tail + AW'(1);
        count_nxt = count + (AW+1)'(1);
      end
      READ: begin
        re        = 1'b1;
        head_nxt  = head + AW'(1);
        count_nxt = count - (AW+1)'(1);
      end
      RDWR: begin
        we       = 1'b1;
        re       = 1'b1;
        head_nxt = head + AW'(1);
        tail_nxt = tail + AW'(1);
      end
      INIT, NO_OP, WR_ERROR, RD_ERROR: ;
      default: begin
        head_nxt  = 'x;
        tail_nxt  = 'x;
        count_nxt = 'x;
        we        = 1'bx;
        re        = 1'bx;
      end
    endcase
  end

endmodule

// File: rtl/fifo_param.sv
// Parametrised synchronous FIFO with registered read data, fill-level flags
// and one-cycle ack/err pulses. Optional per-direction error counters are
// built when FIFO_ERR_CNT_EN is defined.
module fifo_param
  import fifo_param_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 8,
  parameter int AF_LVL = 6,
  parameter int AE_LVL = 2,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [AW:0]      data_count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             wr_ack,
  output logic             wr_err,
  output logic             rd_ack,
  output logic             rd_err
`ifdef FIFO_ERR_CNT_EN
  ,
  output logic [7:0]       wr_err_cnt,
  output logic [7:0]       rd_err_cnt
`endif
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_C    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_C    = (AW+1)'(AE_LVL);

  state_t          state;
  state_t          state_nxt;
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic [AW-1:0]   head_nxt;
  logic [AW-1:0]   tail_nxt;
  logic [AW:0]     count_nxt;
  logic            we;
  logic            re;
  logic            rd_on_empty;
  logic [WIDTH-1:0] mem [DEPTH];

  assign state_nxt = fifo_next_state(wr_en, rd_en, full, empty);

  fifo_param_cal #(.DEPTH(DEPTH)) u_cal (
    .state_nxt (state_nxt),
    .head      (head),
    .tail      (tail),
    .count     (data_count),
    .head_nxt  (head_nxt),
    .tail_nxt  (tail_nxt),
    .count_nxt (count_nxt),
    .we        (we),
    .re        (re)
  );

  // State, pointers, count and read data advance together on each edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= INIT;
      head        <= '0;
      tail        <= '0;
      data_count  <= '0;
      dout        <= '0;
      rd_on_empty <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values; at full
      // a RDWR reads mem[head] before the same slot is overwritten.
      state       <= state_nxt;
      head        <= head_nxt;
      tail        <= tail_nxt;
      data_count  <= count_nxt;
      rd_on_empty <= wr_en & rd_en & empty;
      if (re) dout <= mem[head];
    end
  end

  // Storage write port.
  always_ff @(posedge clk) begin
    // NOTE: the array has no reset; contents are only meaningful once written.
    if (we) mem[tail] <= din;
  end

  assign full         = (data_count == DEPTH_C);
  assign empty        = (data_count == '0);
  assign almost_full  = (data_count >= AF_C);
  assign almost_empty = (data_count <= AE_C);

  assign wr_ack = (state == WRITE) || (state == RDWR);
  assign wr_err = (state == WR_ERROR);
  assign rd_ack = (state == READ) || (state == RDWR);
  assign rd_err = (state == RD_ERROR) || rd_on_empty;

`ifdef FIFO_ERR_CNT_EN
  // Saturating tallies of rejected writes and reads.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_err_cnt <= '0;
      rd_err_cnt <= '0;
    end else begin
      if (wr_err && wr_err_cnt != 8'hFF) wr_err_cnt <= wr_err_cnt + 8'd1;
      if (rd_err && rd_err_cnt != 8'hFF) rd_err_cnt <= rd_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_param.sv
// Self-checking bench for fifo_param (DEPTH=8, WIDTH=32, AF_LVL=6, AE_LVL=2):
// table-driven fill/overflow/drain vectors, hand-written corner sequences,
// and random traffic compared with a queue-based reference model.
module tb_fifo_param;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout;
  logic [3:0]       data_count;
  logic full, empty, almost_full, almost_empty;
  logic wr_ack, wr_err, rd_ack, rd_err;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [WIDTH-1:0] m_q[$];
  logic [WIDTH-1:0] m_dout = '0;
  bit m_wr_ack, m_wr_err, m_rd_ack, m_rd_err;

  typedef struct {
    bit               wr;
    bit               rd;
    logic [WIDTH-1:0] din;
    logic [WIDTH-1:0] dout;
    int               cnt;
    bit               wr_ack;
    bit               wr_err;
    bit               rd_ack;
    bit               rd_err;
  } vec_t;

  vec_t vecs[$];

  fifo_param #(.WIDTH(32), .DEPTH(8), .AF_LVL(6), .AE_LVL(2)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .rd_en        (rd_en),
    .din          (din),
    .dout         (dout),
    .data_count   (data_count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .wr_ack       (wr_ack),
    .wr_err       (wr_err),
    .rd_ack       (rd_ack),
    .rd_err       (rd_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input bit wr, input bit rd, input logic [WIDTH-1:0] d);
    m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
    if (wr && rd) begin
      if (m_q.size() == 0) begin
        m_q.push_back(d); m_wr_ack = 1; m_rd_err = 1;
      end else begin
        m_dout = m_q.pop_front(); m_q.push_back(d); m_wr_ack = 1; m_rd_ack = 1;
      end
    end else if (wr) begin
      if (m_q.size() == DEPTH) m_wr_err = 1;
      else begin m_q.push_back(d); m_wr_ack = 1; end
    end else if (rd) begin
      if (m_q.size() == 0) m_rd_err = 1;
      else begin m_dout = m_q.pop_front(); m_rd_ack = 1; end
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_dout = '0;
    m_wr_ack = 0; m_wr_err = 0; m_rd_ack = 0; m_rd_err = 0;
  endtask

  task automatic check_flags(input string tag, input int n);
    check({tag, " data_count"},   64'(data_count),   64'(n));
    check({tag, " full"},         64'(full),         64'(n == DEPTH));
    check({tag, " empty"},        64'(empty),        64'(n == 0));
    check({tag, " almost_full"},  64'(almost_full),  64'(n >= 6));
    check({tag, " almost_empty"}, 64'(almost_empty), 64'(n <= 2));
  endtask

  task automatic compare_model(input string tag);
    check({tag, " dout"},   64'(dout),   64'(m_dout));
    check({tag, " wr_ack"}, 64'(wr_ack), 64'(m_wr_ack));
    check({tag, " wr_err"}, 64'(wr_err), 64'(m_wr_err));
    check({tag, " rd_ack"}, 64'(rd_ack), 64'(m_rd_ack));
    check({tag, " rd_err"}, 64'(rd_err), 64'(m_rd_err));
    check_flags(tag, m_q.size());
  endtask

  // One request cycle: drive on the falling edge, sample 1 ns after rising.
  task automatic step(input bit wr, input bit rd, input logic [WIDTH-1:0] d, input string tag);
    @(negedge clk);
    wr_en = wr; rd_en = rd; din = d;
    @(posedge clk);
    #1;
    model_step(wr, rd, d);
    compare_model(tag);
  endtask

  initial begin
    reset_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; din = '0;

    // vectors: 8 writes, overflow write, 8 reads, underflow read
    for (int i = 0; i < 8; i++)
      vecs.push_back('{wr: 1, rd: 0, din: 32'(32'h10 + i), dout: '0, cnt: i + 1,
                       wr_ack: 1, wr_err: 0, rd_ack: 0, rd_err: 0});
    vecs.push_back('{wr: 1, rd: 0, din: 32'hDEAD_BEEF, dout: '0, cnt: 8,
                     wr_ack: 0, wr_err: 1, rd_ack: 0, rd_err: 0});
    for (int i = 0; i < 8; i++)
      vecs.push_back('{wr: 0, rd: 1, din: '0, dout: 32'(32'h10 + i), cnt: 7 - i,
                       wr_ack: 0, wr_err: 0, rd_ack: 1, rd_err: 0});
    vecs.push_back('{wr: 0, rd: 1, din: '0, dout: 32'h17, cnt: 0,
                     wr_ack: 0, wr_err: 0, rd_ack: 0, rd_err: 1});

    repeat (2) @(negedge clk);
    check("reset dout",   64'(dout),   64'h0);
    check("reset wr_ack", 64'(wr_ack), 64'h0);
    check("reset wr_err", 64'(wr_err), 64'h0);
    check("reset rd_ack", 64'(rd_ack), 64'h0);
    check("reset rd_err", 64'(rd_err), 64'h0);
    check_flags("reset", 0);
    reset_n = 1'b1;

    // table-driven fill / overflow / drain / underflow
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].wr, vecs[i].rd, vecs[i].din, "vec model");
      check($sformatf("vec%0d dout", i),   64'(dout),       64'(vecs[i].dout));
      check($sformatf("vec%0d count", i),  64'(data_count), 64'(vecs[i].cnt));
      check($sformatf("vec%0d wr_ack", i), 64'(wr_ack),     64'(vecs[i].wr_ack));
      check($sformatf("vec%0d wr_err", i), 64'(wr_err),     64'(vecs[i].wr_err));
      check($sformatf("vec%0d rd_ack", i), 64'(rd_ack),     64'(vecs[i].rd_ack));
      check($sformatf("vec%0d rd_err", i), 64'(rd_err),     64'(vecs[i].rd_err));
    end

    // simultaneous read+write while full
    for (int i = 0; i < 8; i++) step(1, 0, 32'(32'h20 + i), "fill2");
    step(1, 1, 32'hAA, "rdwr_full");
    check("rdwr_full rd_ack", 64'(rd_ack), 64'h1);
    check("rdwr_full wr_ack", 64'(wr_ack), 64'h1);
    check("rdwr_full dout",   64'(dout),   64'h20);
    check("rdwr_full count",  64'(data_count), 64'h8);
    for (int i = 0; i < 8; i++) step(0, 1, '0, "drain2");
    check("drain2 last dout", 64'(dout), 64'hAA);
    check("drain2 empty",     64'(empty), 64'h1);

    // pointer wrap
    for (int i = 0; i < 5; i++) step(1, 0, 32'(32'h30 + i), "wrap w5");
    for (int i = 0; i < 5; i++) step(0, 1, '0, "wrap r5");
    for (int i = 0; i < 6; i++) step(1, 0, 32'(32'h40 + i), "wrap w6");
    for (int i = 0; i < 6; i++) begin
      step(0, 1, '0, "wrap r6");
      check($sformatf("wrap r6 dout%0d", i), 64'(dout), 64'(32'h40 + i));
    end
    check("wrap count", 64'(data_count), 64'h0);

    // read+write on empty, then asynchronous reset mid-stream
    step(1, 1, 32'h55, "rdwr_empty");
    check("rdwr_empty wr_ack", 64'(wr_ack), 64'h1);
    check("rdwr_empty rd_err", 64'(rd_err), 64'h1);
    check("rdwr_empty count",  64'(data_count), 64'h1);
    step(1, 0, 32'h56, "pre_reset");
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async_rst count", 64'(data_count), 64'h0);
    check("async_rst empty", 64'(empty), 64'h1);
    check("async_rst dout",  64'(dout),  64'h0);
    check("async_rst wr_ack", 64'(wr_ack), 64'h0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic: write-biased phase then read-biased phase
    for (int i = 0; i < 400; i++) begin
      int wp;
      wp = (i < 200) ? 70 : 30;
      step($urandom_range(0, 99) < wp, $urandom_range(0, 99) < (100 - wp),
           $urandom, "rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
